// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's two handshakes: the instruction-memory
// request channel and the IF/ID channel towards decode.
//
// Handshake semantics:
//   imem: imem_req high means a request for imem_addr is pending. imem_addr
//   holds steady while imem_req stays high and imem_ack has not been seen.
//   imem_ack high in a cycle where imem_req is high completes the request in
//   that cycle, and imem_rdata is valid then. imem_ack is ignored while
//   imem_req is low. The memory must tolerate imem_req falling without an ack
//   (reset abandons a request).
//   decode: d_valid high means IF/ID holds an instruction. The instruction is
//   taken (consumed) in a cycle where d_valid and d_available are both high.
//   redirect is honoured only in a consume cycle.
interface fetch_stage_if;
  // decode side
  logic        d_available;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic [31:0] d_pc4;
  // instruction memory side
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // current FSM state, for observation only
  logic [1:0]  state_dbg;

  modport master (
    input  d_available, redirect, redirect_pc, imem_ack, imem_rdata,
    output d_valid, d_inst, d_pc, d_pc4, imem_req, imem_addr, state_dbg
  );

  modport slave (
    output d_available, redirect, redirect_pc, imem_ack, imem_rdata,
    input  d_valid, d_inst, d_pc, d_pc4, imem_req, imem_addr, state_dbg
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the fetch address, talks req/ack to an
// instruction memory of arbitrary latency, and feeds the IF/ID register
// backed by a one-entry skid buffer. Redirects come from decode and are only
// honoured when decode takes its current instruction; a request already in
// flight when a redirect arrives is allowed to finish and its data dropped.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  // architectural state
  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] drop_target;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic        d_valid_q;
  logic [31:0] d_inst_q;
  logic [31:0] d_pc_q;
  logic [31:0] d_pc4_q;

  // next-state values
  logic [1:0]  state_n;
  logic [31:0] fetch_pc_n;
  logic [31:0] drop_target_n;
  logic [31:0] skid_inst_n;
  logic [31:0] skid_pc_n;
  logic        d_valid_n;
  logic [31:0] d_inst_n;
  logic [31:0] d_pc_n;
  logic [31:0] d_pc4_n;

  // handshake qualifiers
  logic        consume;
  logic        slot_free;
  logic        take_redirect;
  logic [31:0] redirect_target;
  logic [31:0] fetch_pc_plus4;
  logic [31:0] skid_pc_plus4;
  logic        unused_redirect_bits;

  // Decode takes IF/ID this cycle; only then may IF/ID reload or redirect act.
  always_comb begin
    consume         = d_valid_q & bus.d_available;
    slot_free       = ~d_valid_q | consume;
    take_redirect   = bus.redirect & consume;
    redirect_target = {bus.redirect_pc[31:2], 2'b00};
    fetch_pc_plus4  = fetch_pc + 32'd4;
    skid_pc_plus4   = skid_pc + 32'd4;
  end

  // The low target bits are word-offset bits and are forced to zero.
  assign unused_redirect_bits = ^bus.redirect_pc[1:0];

  // Next-state logic for the fetch FSM and all datapath registers.
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    drop_target_n = drop_target;
    skid_inst_n   = skid_inst;
    skid_pc_n     = skid_pc;
    d_valid_n     = d_valid_q;
    d_inst_n      = d_inst_q;
    d_pc_n        = d_pc_q;
    d_pc4_n       = d_pc4_q;

    case (state)
      ST_IDLE: begin
        state_n = ST_FETCH;
      end

      ST_FETCH: begin
        if (take_redirect) begin
          // The instruction being consumed is the branch; nothing follows it
          // into IF/ID until the target arrives.
          d_valid_n = 1'b0;
          if (bus.imem_ack) begin
            fetch_pc_n = redirect_target;
          end else begin
            // Wrong-path request still outstanding: let it finish first.
            drop_target_n = redirect_target;
            state_n       = ST_DROP;
          end
        end else if (bus.imem_ack && slot_free) begin
          d_valid_n  = 1'b1;
          d_inst_n   = bus.imem_rdata;
          d_pc_n     = fetch_pc;
          d_pc4_n    = fetch_pc_plus4;
          fetch_pc_n = fetch_pc_plus4;
        end else if (bus.imem_ack) begin
          // IF/ID is occupied and stalled: park the word in the skid buffer
          // and stop requesting until it drains.
          skid_inst_n = bus.imem_rdata;
          skid_pc_n   = fetch_pc;
          fetch_pc_n  = fetch_pc_plus4;
          state_n     = ST_HOLD;
        end else if (consume) begin
          d_valid_n = 1'b0;
        end
      end

      ST_HOLD: begin
        if (take_redirect) begin
          // The skid word is on the wrong path; it is simply never used.
          d_valid_n  = 1'b0;
          fetch_pc_n = redirect_target;
          state_n    = ST_FETCH;
        end else if (consume) begin
          d_inst_n = skid_inst;
          d_pc_n   = skid_pc;
          d_pc4_n  = skid_pc_plus4;
          state_n  = ST_FETCH;
        end
      end

      ST_DROP: begin
        if (bus.imem_ack) begin
          fetch_pc_n = drop_target;
          state_n    = ST_FETCH;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC;
      drop_target <= 32'h0;
      skid_inst   <= 32'h0;
      skid_pc     <= 32'h0;
      d_valid_q   <= 1'b0;
      d_inst_q    <= 32'h0;
      d_pc_q      <= 32'h0;
      d_pc4_q     <= 32'h0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      drop_target <= drop_target_n;
      skid_inst   <= skid_inst_n;
      skid_pc     <= skid_pc_n;
      d_valid_q   <= d_valid_n;
      d_inst_q    <= d_inst_n;
      d_pc_q      <= d_pc_n;
      d_pc4_q     <= d_pc4_n;
    end
  end

  // Outputs: a request is pending exactly in FETCH and DROP.
  always_comb begin
    bus.imem_req  = (state == ST_FETCH) || (state == ST_DROP);
    bus.imem_addr = fetch_pc;
    bus.d_valid   = d_valid_q;
    bus.d_inst    = d_inst_q;
    bus.d_pc      = d_pc_q;
    bus.d_pc4     = d_pc4_q;
    bus.state_dbg = state;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a
// randomized run, all observed by an architectural model that knows only the
// program-order rule (next pc = pc+4, or the redirect target when a redirect
// is taken) and the memory contents.
module tb_fetch_stage;

  logic clk;
  logic rst_n;

  fetch_stage_if bus ();
  fetch_stage_if wbus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wbus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory contents ----------------
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory responders ----------------
  int lat_lo = 0;
  int lat_hi = 0;
  int lat_cur;
  int wait_cnt;

  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= lat_cur);
  assign bus.imem_rdata = mem_fn(bus.imem_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
      lat_cur  <= lat_lo;
    end else if (!bus.imem_req || bus.imem_ack) begin
      wait_cnt <= 0;
      lat_cur  <= $urandom_range(lat_hi, lat_lo);
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  assign wbus.imem_ack    = wbus.imem_req;
  assign wbus.imem_rdata  = mem_fn(wbus.imem_addr);
  assign wbus.d_available = 1'b1;
  assign wbus.redirect    = 1'b0;
  assign wbus.redirect_pc = 32'h0;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- architectural model / scoreboard ----------------
  logic [31:0] exp_pc;
  logic        prev_pend;
  logic [31:0] prev_addr;
  int          gap;
  int          max_gap = 0;
  int          n_consumed = 0;

  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      exp_pc    = 32'h0;
      prev_pend = 1'b0;
      gap       = 0;
    end else begin
      if (prev_pend) begin
        check("req_hold", {31'b0, bus.imem_req}, 32'd1);
        check("addr_hold", bus.imem_addr, prev_addr);
      end
      if (bus.d_valid) begin
        check("model_pc", bus.d_pc, exp_pc);
        check("model_inst", bus.d_inst, mem_fn(exp_pc));
        check("model_pc4", bus.d_pc4, exp_pc + 32'd4);
        gap = 0;
      end else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
      if (bus.d_valid && bus.d_available) begin
        n_consumed++;
        exp_pc = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : exp_pc + 32'd4;
      end
      prev_pend = bus.imem_req && !bus.imem_ack;
      prev_addr = bus.imem_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", {31'b0, bus.d_valid}, 32'd0);
    check("rst_inst", bus.d_inst, 32'h0);
    check("rst_pc", bus.d_pc, 32'h0);
    check("rst_pc4", bus.d_pc4, 32'h0);
    check("rst_state", {30'b0, bus.state_dbg}, 32'd0);
    check("rst_w_addr", wbus.imem_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.d_valid && bus.d_pc == pc) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'b0, found}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.d_valid) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'b0, found}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    rst_n           = 1'b0;
    bus.d_available = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Zero-wait streaming from 0, plus the wrapping instance alongside.
    lat_lo = 0; lat_hi = 0;
    apply_reset();
    check("idle_req", {31'b0, bus.imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'b0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h0);
    check("first_valid", {31'b0, bus.d_valid}, 32'd0);
    check("w_first_addr", wbus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("s1_addr", bus.imem_addr, 32'h4);
    check("s1_valid", {31'b0, bus.d_valid}, 32'd1);
    check("s1_pc", bus.d_pc, 32'h0);
    check("s1_inst", bus.d_inst, 32'h1357_9BDF);
    check("s1_pc4", bus.d_pc4, 32'h4);
    check("w_pc", wbus.d_pc, 32'hFFFF_FFFC);
    check("w_pc4_wrap", wbus.d_pc4, 32'h0);
    check("w_addr_wrap", wbus.imem_addr, 32'h0);
    @(negedge clk);
    check("s2_addr", bus.imem_addr, 32'h8);
    check("s2_pc", bus.d_pc, 32'h4);
    check("s2_inst", bus.d_inst, 32'h1353_9BDF);
    check("w_pc_after_wrap", wbus.d_pc, 32'h0);
    @(negedge clk);
    check("s3_addr", bus.imem_addr, 32'hC);
    check("s3_pc", bus.d_pc, 32'h8);

    // Three-cycle decode stall with 0x8 in IF/ID.
    bus.d_available = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req", {31'b0, bus.imem_req}, 32'd0);
      check("stall_valid", {31'b0, bus.d_valid}, 32'd1);
      check("stall_pc", bus.d_pc, 32'h8);
    end
    bus.d_available = 1'b1;
    @(negedge clk);
    check("rel_pc_c", bus.d_pc, 32'hC);
    check("rel_addr", bus.imem_addr, 32'h10);
    @(negedge clk);
    check("rel_pc_10", bus.d_pc, 32'h10);

    // Redirect with a same-cycle ack for the fall-through word.
    wait_pc(32'h20, "reach_20");
    check("rd_addr_24", bus.imem_addr, 32'h24);
    check("rd_ack", {31'b0, bus.imem_ack}, 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    @(negedge clk);
    bus.redirect = 1'b0;
    check("rd_bubble", {31'b0, bus.d_valid}, 32'd0);
    check("rd_addr_100", bus.imem_addr, 32'h100);
    @(negedge clk);
    check("rd_valid", {31'b0, bus.d_valid}, 32'd1);
    check("rd_pc_100", bus.d_pc, 32'h100);

    // Three-cycle memory, redirect while the 0x40 request is outstanding.
    lat_lo = 2; lat_hi = 2;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == 32'h40) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_req_40", {31'b0, found}, 32'd1);
    check("dr_pc_3c", bus.d_pc, 32'h3C);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    @(negedge clk);
    bus.redirect = 1'b0;
    check("dr_req1", {31'b0, bus.imem_req}, 32'd1);
    check("dr_addr1", bus.imem_addr, 32'h40);
    check("dr_valid1", {31'b0, bus.d_valid}, 32'd0);
    @(negedge clk);
    check("dr_addr2", bus.imem_addr, 32'h40);
    check("dr_ack2", {31'b0, bus.imem_ack}, 32'd1);
    @(negedge clk);
    check("dr_addr_200", bus.imem_addr, 32'h200);
    check("dr_valid3", {31'b0, bus.d_valid}, 32'd0);
    wait_valid("dr_first_valid");
    check("dr_pc_200", bus.d_pc, 32'h200);

    // Reset asserted in the middle of a request.
    check("mid_req_pending", {31'b0, bus.imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_req", {31'b0, bus.imem_req}, 32'd0);
    check("mr_addr", bus.imem_addr, 32'h0);
    check("mr_valid", {31'b0, bus.d_valid}, 32'd0);
    check("mr_inst", bus.d_inst, 32'h0);
    check("mr_pc", bus.d_pc, 32'h0);
    check("mr_pc4", bus.d_pc4, 32'h0);
    check("mr_w_req", {31'b0, wbus.imem_req}, 32'd0);
    check("mr_w_addr", wbus.imem_addr, 32'hFFFF_FFFC);

    // Redirect while the skid buffer is full.
    lat_lo = 0; lat_hi = 0;
    apply_reset();
    wait_pc(32'h10, "reach_10");
    bus.d_available = 1'b0;
    @(negedge clk);
    check("hold_req", {31'b0, bus.imem_req}, 32'd0);
    check("hold_pc", bus.d_pc, 32'h10);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    @(negedge clk);
    check("ign_rd_pc", bus.d_pc, 32'h10);
    check("ign_rd_req", {31'b0, bus.imem_req}, 32'd0);
    bus.d_available = 1'b1;
    bus.redirect_pc = 32'h303;
    @(negedge clk);
    bus.redirect = 1'b0;
    check("hr_valid", {31'b0, bus.d_valid}, 32'd0);
    check("hr_addr", bus.imem_addr, 32'h300);
    @(negedge clk);
    check("hr_valid2", {31'b0, bus.d_valid}, 32'd1);
    check("hr_pc", bus.d_pc, 32'h300);

    // Randomized run against the architectural model.
    apply_reset();
    max_gap    = 0;
    n_consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 500 == 0) begin
        lat_lo = $urandom_range(1, 0);
        lat_hi = lat_lo + $urandom_range(2, 0);
      end
      bus.d_available = ($urandom_range(3, 0) != 0);
      bus.redirect    = ($urandom_range(5, 0) == 0);
      bus.redirect_pc = $urandom;
    end
    @(negedge clk);
    bus.d_available = 1'b1;
    bus.redirect    = 1'b0;
    repeat (20) @(negedge clk);
    check("rand_max_gap_ok", {31'b0, (max_gap <= 16)}, 32'd1);
    check("rand_progress_ok", {31'b0, (n_consumed >= 200)}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage feeding the decode stage of the five-stage MIPS pipeline. It holds the fetch address and runs a req/ack handshake with instruction memory of arbitrary latency. Fetched words go into the IF/ID register and a one-entry skid buffer. The stage holds when decode reports `d_available` low, and redirects on a taken jump/branch resolved in decode. Wrong-path responses are discarded. There is no branch delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `d_available`  in  1  decode can accept its current instruction this cycle (hazard unit output)
- `redirect`  in  1  decode resolved a taken jump/branch this cycle
- `redirect_pc`  in  32  target address; bits [1:0] ignored and treated as 0
- `imem_req`  out  1  fetch request pending
- `imem_addr`  out  32  address of the pending request
- `imem_ack`  in  1  `imem_rdata` valid; request complete this cycle
- `imem_rdata`  in  32  fetched instruction word
- `d_valid`  out  1  IF/ID register holds an instruction
- `d_inst`  out  32  instruction in IF/ID
- `d_pc`  out  32  address of `d_inst`
- `d_pc4`  out  32  `d_pc`+4, registered

## Operation
- Signal definitions:
  - consume = `d_valid` & `d_available`.
  - slot_free = ~`d_valid` | consume.
  - take_redirect = `redirect` & consume. `redirect` is ignored at all other times.
- Registers:
  - fetch_pc: drives `imem_addr`.
  - drop_target (32).
  - skid (inst + pc).
  - IF/ID (`d_valid`, `d_inst`, `d_pc`, `d_pc4`).
  - 2-bit state.
- `imem_req` = 1 exactly in FETCH and DROP. `imem_addr` stays stable while `imem_req` is high until `imem_ack`. `imem_ack` is ignored when `imem_req` is 0.
- IDLE (reset state):
  - next state FETCH unconditionally.
- FETCH:
  - If take_redirect, the IF/ID register loads nothing and `d_valid` goes to 0.
    - With `imem_ack`: discard `imem_rdata`, set fetch_pc to the target, stay in FETCH.
    - Without `imem_ack`: set drop_target to the target, go to DROP.
  - Else if `imem_ack` and slot_free: load IF/ID with {rdata, fetch_pc, fetch_pc+4}, set `d_valid`=1, set fetch_pc to fetch_pc+4, stay in FETCH.
  - Else if `imem_ack` and not slot_free: load skid with {rdata, fetch_pc}, set fetch_pc to fetch_pc+4, go to HOLD.
  - Else: if consume, clear `d_valid`; stay in FETCH.
- HOLD (`imem_req`=0):
  - If take_redirect: discard skid, clear `d_valid`, set fetch_pc to the target, go to FETCH.
  - Else if consume: move skid into IF/ID, go to FETCH.
  - Else: stay in HOLD.
- DROP:
  - `d_valid` is 0 in this state, so no redirect is possible.
  - On `imem_ack`: discard the data, set fetch_pc to drop_target, go to FETCH.
- Arithmetic: all +4 additions are modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
- Reset values: state IDLE, fetch_pc=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `d_valid`=0, `d_inst`=0, `d_pc`=0, `d_pc4`=0, skid=0, drop_target=0. Reset asserted mid-request abandons the request. Memory must tolerate `imem_req` dropping without an ack.

## Timing
- First request: `imem_req` rises in the first cycle after `rst_n` deasserts.
- Zero-wait memory (ack in the same cycle as the request): the instruction is on `d_inst` in the next cycle. Throughput is 1 instruction/cycle with `d_available`=1.
- N-cycle memory latency gives 1 instruction per N cycles.
- Redirect penalty with a same-cycle ack: the target request is on `imem_addr` the next cycle. The target instruction reaches `d_inst` 2 cycles after redirect with zero-wait memory.
- Redirect without a same-cycle ack: the wrong-path request runs to completion first, then the target request issues the following cycle.
- A decode stall never loses a word: at most 2 instructions are buffered (IF/ID + skid). No new request issues while the skid is full.

## Test plan
- Reset, zero-wait memory, `d_available`=1, `RESET_PC`=0: `imem_addr` is 0,4,8,... on consecutive cycles. `d_inst`/`d_pc` follow one cycle later, `d_pc4`=`d_pc`+4.
- Stall: hold `d_available`=0 for 3 cycles while `d_inst`@0x8 is valid. 0xC is captured in the skid, `imem_req`=0. On release, `d_pc` runs 0x8, 0xC, 0x10 with no gap or duplicate.
- Redirect to 0x100 with `d_pc`=0x20 and a same-cycle ack for 0x24: 0x24 is never presented. The next `imem_addr` is 0x100, then `d_pc`=0x100.
- 3-cycle memory, redirect to 0x200 while the 0x40 request is outstanding: `imem_addr` holds 0x40 until its ack and that data is dropped. 0x200 issues next cycle, and the first valid `d_pc` is 0x200.
- Redirect while in HOLD: the skid word is discarded and the next valid `d_pc` equals `redirect_pc`. `redirect` with `d_available`=0 has no effect.
- Wrap and reset: `RESET_PC`=32'hFFFF_FFFC gives `d_pc4`=0 and next `imem_addr`=0. Pulse `rst_n` low mid-request: all outputs return to their reset values immediately.
